// File: rtl/smi_arbiter.sv
// Round-robin arbiter sharing one SMI/MDIO read-write engine between N_REQ requesters.
// One transaction in flight at a time; completion, read data and timeout go back to the granted requester.
module smi_arbiter #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  smi_ready,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      we,
    input  logic [5*N_REQ-1:0]    phy_addr,
    input  logic [5*N_REQ-1:0]    reg_addr,
    input  logic [16*N_REQ-1:0]   wdata,
    output logic [N_REQ-1:0]      ack,
    output logic                  err,
    output logic [15:0]           rdata,
    output logic                  busy,
    output logic [4:0]            smi_phy_addr,
    output logic [4:0]            smi_reg_addr,
    output logic [15:0]           smi_write_data,
    output logic                  smi_write_req,
    output logic                  smi_read_req,
    input  logic [15:0]           smi_read_data,
    input  logic                  smi_data_valid,
    input  logic                  smi_done
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              err_q, err_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic [4:0]        phy_q, phy_d;
    logic [4:0]        reg_q, reg_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;

    logic              start;
    logic              timeout;
    logic [IW-1:0]     sel;

    // First set request scanning upward from the one after the last served requester.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IW-1:0] last);
        logic [IW-1:0] pick;
        logic          found;
        int            j;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(last) + k) % N_REQ;
            if (!found && r[j]) begin
                pick  = IW'(j);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign start   = smi_ready && (|req);
    assign sel     = rr_pick(req, last_q);
    assign timeout = (timer_q == T_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   state_d = BUSY;
            BUSY:    if (smi_done || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        timer_d = timer_q;
        ack_d   = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        phy_d   = phy_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        busy_d  = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    grant_d = sel;
                    phy_d   = phy_addr[5*int'(sel) +: 5];
                    reg_d   = reg_addr[5*int'(sel) +: 5];
                    wdata_d = wdata[16*int'(sel) +: 16];
                    wr_d    = we[sel];
                    rd_d    = !we[sel];
                end
            end
            ISSUE: timer_d = '0;
            BUSY: begin
                timer_d = timer_q + TW'(1);
                if (smi_data_valid) rdata_d = smi_read_data;
                // A completion on the final timer cycle still counts as success.
                if (smi_done) begin
                    ack_d[grant_q] = 1'b1;
                end else if (timeout) begin
                    ack_d[grant_q] = 1'b1;
                    err_d          = 1'b1;
                end
            end
            RESP: last_d = grant_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            last_q  <= LAST_INIT;
            timer_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            phy_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            phy_q   <= phy_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    assign ack            = ack_q;
    assign err            = err_q;
    assign rdata          = rdata_q;
    assign busy           = busy_q;
    assign smi_phy_addr   = phy_q;
    assign smi_reg_addr   = reg_q;
    assign smi_write_data = wdata_q;
    assign smi_write_req  = wr_q;
    assign smi_read_req   = rd_q;

endmodule

// File: tb/tb_smi_arbiter.sv
// Bench for smi_arbiter: directed vectors, multi-cycle corner sequences and a randomized
// run checked against a transaction-level model of the arbitration and timing rules.
module tb_smi_arbiter;
    localparam int N  = 2;
    localparam int TO = 48;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              smi_ready = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      we;
    logic [5*N-1:0]    phy_addr, reg_addr;
    logic [16*N-1:0]   wdata;
    logic [N-1:0]      ack;
    logic              err;
    logic [15:0]       rdata;
    logic              busy;
    logic [4:0]        smi_phy_addr, smi_reg_addr;
    logic [15:0]       smi_write_data;
    logic              smi_write_req, smi_read_req;
    logic [15:0]       smi_read_data = '0;
    logic              smi_data_valid = 1'b0;
    logic              smi_done = 1'b0;

    logic              r_we  [N];
    logic [4:0]        r_phy [N];
    logic [4:0]        r_reg [N];
    logic [15:0]       r_wd  [N];

    int checks, errors;

    // engine model state
    int          tbl_d, cur_d, cnt, rtmp;
    logic [15:0] tbl_data, cur_data;
    logic        rand_mode, pend, eng_wr;

    typedef struct {
        int          idx;
        logic        w;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] wd;
        int          d;
        logic [15:0] edata;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          lat;
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            we[i]             = r_we[i];
            phy_addr[5*i +: 5] = r_phy[i];
            reg_addr[5*i +: 5] = r_reg[i];
            wdata[16*i +: 16]  = r_wd[i];
        end
    end

    smi_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .smi_ready(smi_ready), .req(req), .we(we),
        .phy_addr(phy_addr), .reg_addr(reg_addr), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .smi_phy_addr(smi_phy_addr), .smi_reg_addr(smi_reg_addr),
        .smi_write_data(smi_write_data), .smi_write_req(smi_write_req),
        .smi_read_req(smi_read_req), .smi_read_data(smi_read_data),
        .smi_data_valid(smi_data_valid), .smi_done(smi_done)
    );

    // Engine: finishes cur_d cycles after the strobe cycle (0 = never answers).
    initial begin
        pend = 1'b0; cnt = 0; cur_d = 0; cur_data = '0; eng_wr = 1'b0; rtmp = 0;
        forever begin
            @(posedge clk); #1;
            smi_done = 1'b0;
            smi_data_valid = 1'b0;
            if (!rst_n) pend = 1'b0;
            if (pend) begin
                cnt++;
                if (cnt == cur_d) begin
                    smi_done = 1'b1;
                    smi_data_valid = !eng_wr;
                    smi_read_data = cur_data;
                    pend = 1'b0;
                end
            end
            if (rst_n && (smi_read_req || smi_write_req)) begin
                pend = 1'b1;
                cnt = 0;
                eng_wr = smi_write_req;
                if (rand_mode) begin
                    rtmp = int'($urandom_range(1, TO + 6));
                    cur_d = (rtmp > TO) ? 0 : rtmp;
                    cur_data = 16'($urandom);
                end else begin
                    cur_d = tbl_d;
                    cur_data = tbl_data;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int rr(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++)
            if (p[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic wait_strobe();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (smi_read_req || smi_write_req) break;
        end
    endtask

    task automatic wait_ack();
        for (int c = 0; c < TO + 8; c++) begin
            @(negedge clk);
            if (ack != '0) break;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int got;
        @(posedge clk); #1;
        r_we[v.idx] = v.w; r_phy[v.idx] = v.phy; r_reg[v.idx] = v.regad; r_wd[v.idx] = v.wd;
        tbl_d = v.d; tbl_data = v.edata;
        req = '0; req[v.idx] = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("vec_read_req", 32'(smi_read_req), 32'(!v.w));
        chk("vec_write_req", 32'(smi_write_req), 32'(v.w));
        chk("vec_phy", 32'(smi_phy_addr), 32'(v.phy));
        chk("vec_reg", 32'(smi_reg_addr), 32'(v.regad));
        if (v.w) chk("vec_wdata", 32'(smi_write_data), 32'(v.wd));
        got = 0;
        for (int c = 1; c <= TO + 4; c++) begin
            @(posedge clk); @(negedge clk);
            if (ack != '0) begin got = c; break; end
        end
        chk("vec_ack_latency", got, v.lat);
        chk("vec_ack", 32'(ack), 32'(1 << v.idx));
        chk("vec_err", 32'(err), 32'(v.exp_err));
        chk("vec_rdata", 32'(rdata), 32'(v.exp_rdata));
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        chk("vec_ack_pulse", 32'(ack), 0);
        chk("vec_busy_idle", 32'(busy), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_rdata"}, 32'(rdata), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_phy"}, 32'(smi_phy_addr), 0);
        chk({tag, "_reg"}, 32'(smi_reg_addr), 0);
        chk({tag, "_wdata"}, 32'(smi_write_data), 0);
        chk({tag, "_wr"}, 32'(smi_write_req), 0);
        chk({tag, "_rd"}, 32'(smi_read_req), 0);
    endtask

    initial begin
        int n, bad;
        int last_ack, cyc, idle_ok, ack_cyc, cur_g, g;
        logic in_flight, exp_err, strobe, exp_strobe;
        logic [15:0] exp_rd, next_rd;
        logic [N-1:0] prev_req, ack_seen, exp_ack;

        checks = 0; errors = 0; rand_mode = 1'b0; tbl_d = 3; tbl_data = 16'hC0DE;
        for (int i = 0; i < N; i++) begin
            r_we[i] = 1'b0; r_phy[i] = 5'(i + 1); r_reg[i] = 5'(i); r_wd[i] = 16'h0;
        end
        //            idx w    phy    reg     wdata     d       edata     exp_rdata exp_err lat
        tbl[0] = '{0, 1'b0, 5'd1, 5'h01, 16'h0000, 40, 16'h796D, 16'h796D, 1'b0, 41};
        tbl[1] = '{1, 1'b1, 5'd1, 5'h00, 16'h8000, 10, 16'hBEEF, 16'h796D, 1'b0, 11};
        tbl[2] = '{0, 1'b0, 5'd2, 5'h02, 16'h0000, 0,  16'h1111, 16'h796D, 1'b1, TO + 1};
        tbl[3] = '{1, 1'b0, 5'd3, 5'h03, 16'h0000, TO, 16'h1234, 16'h1234, 1'b0, TO + 1};
        tbl[4] = '{0, 1'b1, 5'd4, 5'h1F, 16'hA5A5, 1,  16'h5555, 16'h1234, 1'b0, 2};

        #2 rst_n = 1'b0;
        smi_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");

        // Contention from reset: both requesters held high.
        r_phy[0] = 5'h03; r_phy[1] = 5'h07; tbl_d = 3; tbl_data = 16'hC0DE;
        @(posedge clk); #1 req = '1; rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                chk("rr_single_ack", $countones(ack), 1);
                chk("rr_order", 32'(ack), 32'(1 << (n % 2)));
                n++;
            end
        end
        chk("rr_count", n, 4);
        @(posedge clk); #1 req = '0;

        // Gating: smi_ready low blocks grants.
        @(posedge clk); #1 smi_ready = 1'b0; req[0] = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (smi_read_req || smi_write_req || busy) bad++;
        end
        chk("gated_no_activity", bad, 0);

        // Serve requester 0, then grant 1, then reset mid-BUSY.
        @(posedge clk); #1 smi_ready = 1'b1; tbl_d = 5;
        wait_ack();
        chk("pre_ack0", 32'(ack), 1);
        @(posedge clk); #1 req = '1; tbl_d = 0;
        wait_strobe();
        chk("pre_grant1_strobe", 32'(smi_read_req), 1);
        chk("pre_grant1_phy", 32'(smi_phy_addr), 32'(r_phy[1]));
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_rst_strobe", 32'(smi_read_req), 1);
        chk("post_rst_grant0", 32'(smi_phy_addr), 32'(r_phy[0]));
        @(posedge clk); #1 req = '0; rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Randomized run against the transaction-level model.
        @(posedge clk); #1 rst_n = 1'b0; req = '0;
        @(posedge clk); #1 rst_n = 1'b1; rand_mode = 1'b1;
        last_ack = N - 1; in_flight = 1'b0; exp_rd = '0; next_rd = '0; idle_ok = 0; cyc = 0;
        ack_cyc = 0; cur_g = 0; exp_err = 1'b0; prev_req = '0; ack_seen = '0;
        for (int t = 0; t < 4000; t++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (ack_seen[i]) req[i] = 1'b0;
                else if (!req[i] && t < 3500 && $urandom_range(0, 3) == 0) begin
                    r_we[i] = 1'($urandom); r_phy[i] = 5'($urandom); r_reg[i] = 5'($urandom);
                    r_wd[i] = 16'($urandom); req[i] = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
            strobe = smi_read_req || smi_write_req;
            exp_strobe = !in_flight && (prev_req != '0) && (cyc >= idle_ok);
            chk("rnd_strobe", 32'(strobe), 32'(exp_strobe));
            if (strobe && !in_flight) begin
                g = rr(prev_req, last_ack);
                chk("rnd_grant_valid", 32'(g >= 0), 1);
                if (g >= 0) begin
                    chk("rnd_write_req", 32'(smi_write_req), 32'(r_we[g]));
                    chk("rnd_read_req", 32'(smi_read_req), 32'(!r_we[g]));
                    chk("rnd_phy", 32'(smi_phy_addr), 32'(r_phy[g]));
                    chk("rnd_reg", 32'(smi_reg_addr), 32'(r_reg[g]));
                    if (r_we[g]) chk("rnd_wdata", 32'(smi_write_data), 32'(r_wd[g]));
                    in_flight = 1'b1;
                    cur_g = g;
                    exp_err = (cur_d == 0);
                    ack_cyc = cyc + ((cur_d == 0) ? TO + 1 : cur_d + 1);
                    next_rd = (!r_we[g] && cur_d != 0) ? cur_data : exp_rd;
                end
            end
            exp_ack = (in_flight && cyc == ack_cyc) ? N'(1 << cur_g) : '0;
            chk("rnd_ack", 32'(ack), 32'(exp_ack));
            chk("rnd_busy", 32'(busy), 32'(in_flight));
            if (in_flight && cyc == ack_cyc) begin
                chk("rnd_err", 32'(err), 32'(exp_err));
                chk("rnd_rdata", 32'(rdata), 32'(next_rd));
                exp_rd = next_rd;
                last_ack = cur_g;
                in_flight = 1'b0;
                idle_ok = cyc + 2;
            end
            ack_seen = ack;
            prev_req = req;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
